// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int WIDTH = 32;

  // Function codes
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle by the owning FSM.
//
// Ports:
//   div_mode   1 = restoring divide step, 0 = shift-add multiply step
//   hi         accumulator upper half (MUL) or partial remainder (DIV)
//   lo         multiplier / low product bits (MUL) or dividend / quotient (DIV)
//   opnd       multiplicand (MUL) or divisor (DIV)
//   hi_nx/lo_nx  next hi/lo values
//   qbit       quotient bit produced by a divide step (0 in MUL mode)
module hilo_step #(
  parameter int W = muldiv_pkg::WIDTH
) (
  input  logic         div_mode,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] hi_nx,
  output logic [W-1:0] lo_nx,
  output logic         qbit
);

  logic [W:0]   sum;   // W+1 bits so the add carry survives the shift
  logic [W:0]   acc;
  logic [W:0]   sh;    // {rem, next dividend bit}, W+1 bits for an overflow-free compare
  logic [W-1:0] diff;

  always_comb begin
    sum   = {1'b0, hi} + {1'b0, opnd};
    acc   = lo[0] ? sum : {1'b0, hi};
    sh    = {hi, lo[W-1]};
    // Only used when sh >= opnd, so the true difference fits in W bits.
    diff  = sh[W-1:0] - opnd;
    qbit  = 1'b0;
    hi_nx = hi;
    lo_nx = lo;
    if (div_mode) begin
      if (sh >= {1'b0, opnd}) begin
        qbit  = 1'b1;
        hi_nx = diff;
      end else begin
        hi_nx = sh[W-1:0];
      end
      lo_nx = {lo[W-2:0], qbit};
    end else begin
      // {carry, hi, lo} >> 1: the consumed multiplier bit falls off lo.
      hi_nx = acc[W:1];
      lo_nx = {acc[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multicycle unsigned MULTU/DIVU unit producing the HI/LO register pair.
// Latency: WIDTH cycles from the accepting edge to commit (done pulse).
// Backpressure: start is ignored while busy, except on the commit edge (back-to-back).
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start, Signal  request and function code (MULTU/DIVU; others ignored)
//   dataA, dataB   multiplicand/dividend, multiplier/divisor
//   HiOut, LoOut   committed HI/LO (product high/low, or remainder/quotient)
//   busy, done     operation in progress, one-cycle commit pulse
//   divZero        last committed DIVU had a zero divisor (sticky across MULTU)
module hilo_muldiv #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic             qbit;
  logic             last_step;
  logic             accept;
  logic             is_mul;
  logic             is_div;

  hilo_step #(.W(WIDTH)) u_step (
    .div_mode (state == DIV),
    .hi       (hi_r),
    .lo       (lo_r),
    .opnd     (opnd),
    .hi_nx    (hi_nx),
    .lo_nx    (lo_nx),
    .qbit     (qbit)
  );

  always_comb begin
    is_mul    = (Signal == MULTU);
    is_div    = (Signal == DIVU);
    last_step = (state != IDLE) && (cnt == CW'(WIDTH - 1));
    // A request is taken when idle, or on the commit edge so results can stream.
    accept    = start && (is_mul || is_div) && ((state == IDLE) || last_step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      opnd    <= '0;
      HiOut   <= '0;
      LoOut   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: ;
        MUL, DIV: begin
          hi_r <= hi_nx;
          lo_r <= lo_nx;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            HiOut <= hi_nx;
            LoOut <= lo_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            if (state == DIV) begin
              divZero <= (opnd == '0);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Loading a new operation overrides the step/commit updates of the
      // working registers above; committed outputs are untouched.
      if (accept) begin
        hi_r  <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
        if (is_mul) begin
          state <= MUL;
          opnd  <= dataA;   // multiplicand
          lo_r  <= dataB;   // multiplier, consumed LSB first
        end else begin
          state <= DIV;
          opnd  <= dataB;   // divisor
          lo_r  <= dataA;   // dividend, becomes the quotient
        end
      end
    end
  end

  // qbit is already folded into lo_nx by the step logic.
  logic unused_qbit;
  assign unused_qbit = qbit;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus randomized ops vs a reference model.
// Latency: checks commit exactly 32 clocks after the accepting edge.
// Backpressure: exercises ignored starts while busy and back-to-back acceptance at commit.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  Signal = '0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        busy;
  logic        done;
  logic        divZero;

  hilo_muldiv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .HiOut   (HiOut),
    .LoOut   (LoOut),
    .busy    (busy),
    .done    (done),
    .divZero (divZero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what HI/LO/divZero must read once the pending op commits.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (sig == MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == 32'd0) begin
      exp_hi = a;
      exp_lo = 32'hFFFF_FFFF;
      exp_dz = 1'b1;
    end else begin
      exp_hi = a % b;
      exp_lo = a / b;
      exp_dz = 1'b0;
    end
  endtask

  // Drive a request and let it be taken at the next rising edge (E0).
  task automatic start_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    Signal = sig;
    dataA  = a;
    dataB  = b;
    @(posedge clk);
    #1;
    chk("busy_rise", busy, 1);
    chk("no_done_e0", done, 0);
  endtask

  // Called just after E0. Before edge E<inject> a second request is driven;
  // inject==32 makes it a back-to-back accept, other values must be ignored.
  task automatic wait_result(input string tag, input int inject,
                             input logic [5:0] isig, input logic [31:0] ia,
                             input logic [31:0] ib);
    logic [31:0] p_hi, p_lo;
    logic        p_dz;
    bit          seen;
    p_hi = HiOut;
    p_lo = LoOut;
    p_dz = divZero;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == inject) begin
        start  = 1'b1;
        Signal = isig;
        dataA  = ia;
        dataB  = ib;
      end else begin
        start  = 1'b0;
        dataA  = $urandom;
        dataB  = $urandom;
      end
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        chk({tag, "_latency"}, i, 32);
        chk({tag, "_hi"}, HiOut, exp_hi);
        chk({tag, "_lo"}, LoOut, exp_lo);
        chk({tag, "_dz"}, divZero, exp_dz);
        chk({tag, "_busy"}, busy, (inject == 32) ? 1 : 0);
      end else begin
        chk({tag, "_hold_hi"}, HiOut, p_hi);
        chk({tag, "_hold_lo"}, LoOut, p_lo);
        chk({tag, "_hold_dz"}, divZero, p_dz);
        chk({tag, "_busy_on"}, busy, 1);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    if (inject != 32) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_done_once"}, done, 0);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] sig,
                        input logic [31:0] a, input logic [31:0] b);
    model(sig, a, b);
    start_op(sig, a, b);
    wait_result(tag, 0, 6'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [5:0]  rs;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    chk("rst_hi", HiOut, 0);
    chk("rst_lo", LoOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", divZero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("mul_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_100_7", DIVU, 32'd100, 32'd7);
    run_op("div_zero", DIVU, 32'h1234_5678, 32'd0);
    run_op("mul_3_5", MULTU, 32'd3, 32'd5);

    // Unknown function code is ignored in IDLE
    @(negedge clk);
    start  = 1'b1;
    Signal = 6'b100000;
    dataA  = 32'd9;
    dataB  = 32'd9;
    @(posedge clk);
    #1;
    chk("add_busy", busy, 0);
    chk("add_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("add_busy2", busy, 0);
    chk("add_done2", done, 0);
    chk("add_hi", HiOut, exp_hi);
    chk("add_lo", LoOut, exp_lo);

    // start during a running MULTU is ignored
    model(MULTU, 32'd1234, 32'd5678);
    start_op(MULTU, 32'd1234, 32'd5678);
    wait_result("mul_inj", 10, DIVU, 32'd77, 32'd3);

    // Back-to-back: second op accepted on the commit edge
    model(MULTU, 32'd6, 32'd7);
    start_op(MULTU, 32'd6, 32'd7);
    wait_result("b2b_mul", 32, DIVU, 32'd50, 32'd8);
    model(DIVU, 32'd50, 32'd8);
    wait_result("b2b_div", 0, 6'd0, 32'd0, 32'd0);

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      rs = ($urandom_range(0, 1) == 0) ? MULTU : DIVU;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
      run_op("rand", rs, ra, rb);
    end

    // Reset in the middle of a DIVU
    start_op(DIVU, 32'hDEAD_BEEF, 32'd13);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_hi", HiOut, 0);
    chk("mrst_lo", LoOut, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_dz", divZero, 0);
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mrst_no_done", ndone, 0);
    chk("mrst_idle", busy, 0);
    chk("mrst_hi2", HiOut, 0);

    // Unit still works after the abort
    run_op("post_rst", DIVU, 32'd1000, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
